// File: rtl/fifo_uart_drain_if.sv
// FIFO read-port handshake between the byte FIFO (slave) and the UART drain (master).
interface fifo_uart_drain_if;
    logic       fifo_rd_req;
    logic       fifo_empty;
    logic [7:0] fifo_data;

    modport master (
        output fifo_rd_req,
        input  fifo_empty,
        input  fifo_data
    );

    modport slave (
        input  fifo_rd_req,
        output fifo_empty,
        output fifo_data
    );
endinterface

// File: rtl/fifo_uart_drain.sv
// Pops bytes from the byte FIFO and serialises them as 8N1 UART frames, LSB first.
// Optional even-parity bit between data and stop when DRAIN_PARITY_EN is defined.
module fifo_uart_drain #(
    parameter int CLKS_PER_BIT = 16,
    parameter int COUNT_W      = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   tx_en,
    fifo_uart_drain_if.master      fifo,
    output logic                   tx,
    output logic                   busy,
    output logic [COUNT_W-1:0]     bytes_sent
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_REQ    = 3'd1;
    localparam logic [2:0] S_LOAD   = 3'd2;
    localparam logic [2:0] S_START  = 3'd3;
    localparam logic [2:0] S_DATA   = 3'd4;
    localparam logic [2:0] S_STOP   = 3'd5;
`ifdef DRAIN_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd6;
`endif

    logic [2:0]         state_q, state_d;
    logic [CNT_W-1:0]   baud_q, baud_d;
    logic [2:0]         bit_q, bit_d;
    logic [7:0]         shift_q, shift_d;
    logic               tx_q, tx_d;
    logic               rd_req_q, rd_req_d;
    logic               busy_q, busy_d;
    logic [COUNT_W-1:0] sent_q, sent_d;
    logic               baud_end;
`ifdef DRAIN_PARITY_EN
    logic               parity_q, parity_d;
`endif

    assign baud_end = (baud_q == BAUD_LAST);

    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        sent_d  = sent_q;
`ifdef DRAIN_PARITY_EN
        parity_d = parity_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (tx_en && !fifo.fifo_empty) state_d = S_REQ;
            end
            S_REQ: begin
                // An empty FIFO ignores the request, so there is no byte to load.
                state_d = fifo.fifo_empty ? S_IDLE : S_LOAD;
            end
            S_LOAD: begin
                shift_d = fifo.fifo_data;
`ifdef DRAIN_PARITY_EN
                parity_d = ^fifo.fifo_data;
`endif
                state_d = S_START;
            end
            S_START: begin
                if (baud_end) state_d = S_DATA;
            end
            S_DATA: begin
                if (baud_end) begin
                    shift_d = shift_q >> 1;
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
`ifdef DRAIN_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end
            end
`ifdef DRAIN_PARITY_EN
            S_PARITY: begin
                if (baud_end) state_d = S_STOP;
            end
`endif
            S_STOP: begin
                if (baud_end) begin
                    sent_d  = sent_q + COUNT_W'(1);
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (state_q == S_IDLE || state_d != state_q || baud_end) baud_d = '0;
        else                                                     baud_d = baud_q + CNT_W'(1);

        // Outputs are decoded from the next state so they register alongside it.
        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_d[0];
`ifdef DRAIN_PARITY_EN
            S_PARITY: tx_d = parity_d;
`endif
            default:  tx_d = 1'b1;
        endcase
        rd_req_d = (state_d == S_REQ);
        busy_d   = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            tx_q     <= 1'b1;
            rd_req_q <= 1'b0;
            busy_q   <= 1'b0;
            sent_q   <= '0;
`ifdef DRAIN_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
            rd_req_q <= rd_req_d;
            busy_q   <= busy_d;
            sent_q   <= sent_d;
`ifdef DRAIN_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    assign fifo.fifo_rd_req = rd_req_q;
    assign tx               = tx_q;
    assign busy             = busy_q;
    assign bytes_sent       = sent_q;
endmodule

// File: tb/tb_fifo_uart_drain.sv
// Directed bench for fifo_uart_drain at CLKS_PER_BIT=4, COUNT_W=2 (small counter exposes wrap).
module tb_fifo_uart_drain;
    localparam int CPB = 4;
`ifdef DRAIN_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int P = CPB * NBITS + 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tx_en = 1'b1;
    logic       force_empty = 1'b0;
    logic       tx;
    logic       busy;
    logic [1:0] bytes_sent;

    fifo_uart_drain_if bus ();

    fifo_uart_drain #(.CLKS_PER_BIT(CPB), .COUNT_W(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .tx_en      (tx_en),
        .fifo       (bus.master),
        .tx         (tx),
        .busy       (busy),
        .bytes_sent (bytes_sent)
    );

    always #5 clk = ~clk;

    // Byte FIFO model: registered read data, no pop while empty.
    logic [7:0] mem [16];
    int         wr_ptr = 0;
    int         rd_ptr = 0;

    assign bus.fifo_empty = force_empty || (rd_ptr == wr_ptr);

    always @(posedge clk) begin
        if (bus.fifo_rd_req && !bus.fifo_empty) begin
            bus.fifo_data <= mem[rd_ptr % 16];
            rd_ptr        <= rd_ptr + 1;
        end
    end

    int   checks = 0;
    int   errors = 0;
    logic trace    [0:255];
    logic busy_tr  [0:255];
    int   ncap = 0;
    int   rd_pulses = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] d);
        mem[wr_ptr % 16] = d;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic clear_trace();
        ncap = 0;
        rd_pulses = 0;
    endtask

    // trace[e] holds tx sampled after rising edge e of the current capture window.
    task automatic capture(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (ncap < 255) ncap++;
            trace[ncap]   = tx;
            busy_tr[ncap] = busy;
            if (bus.fifo_rd_req) rd_pulses++;
        end
    endtask

    function automatic int count_lows();
        int n = 0;
        for (int e = 1; e <= ncap; e++) if (trace[e] !== 1'b1) n++;
        return n;
    endfunction

    function automatic int find_fall(input int from);
        for (int e = from; e <= ncap; e++) if (trace[e] === 1'b0) return e;
        return -1;
    endfunction

    function automatic logic [7:0] decode(input int s);
        logic [7:0] d;
        for (int b = 0; b < 8; b++) d[b] = trace[s + CPB * (b + 1) + 1];
        return d;
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        capture(2);
        reset = 1'b0;
    endtask

    int exp_a5 [11];

    initial begin
`ifdef DRAIN_PARITY_EN
        exp_a5 = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 0, 1};
`else
        exp_a5 = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1, 1};
`endif
        // Reset idle
        @(negedge clk);
        capture(2);
        check_eq("rst_tx", tx, 1);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_rdreq", bus.fifo_rd_req, 0);
        check_eq("rst_sent", bytes_sent, 0);
        reset = 1'b0;
        clear_trace();
        capture(100);
        check_eq("idle_lows", count_lows(), 0);
        check_eq("idle_rdreq", rd_pulses, 0);

        // Single byte 0xA5
        push(8'hA5);
        clear_trace();
        capture(P + 5);
        check_eq("a5_pre_start", trace[2], 1);
        check_eq("a5_start_edge", find_fall(1), 3);
        for (int b = 0; b < NBITS; b++)
            check_eq($sformatf("a5_bit%0d", b), trace[3 + CPB * b + 1], exp_a5[b]);
        check_eq("a5_rdreq", rd_pulses, 1);
        check_eq("a5_busy_last", busy_tr[2 + CPB * NBITS], 1);
        check_eq("a5_busy_drop", busy_tr[3 + CPB * NBITS], 0);
        check_eq("a5_sent", bytes_sent, 1);

        // Back-to-back 0x00, 0xFF, 0x3C then wrap
        do_reset();
        push(8'h00); push(8'hFF); push(8'h3C);
        clear_trace();
        capture(3 * P + 5);
        check_eq("b2b_d0", decode(3), 8'h00);
        check_eq("b2b_gap0", trace[CPB * NBITS + 2], 1);
        check_eq("b2b_start1", find_fall(3 + CPB * NBITS), 3 + P);
        check_eq("b2b_d1", decode(3 + P), 8'hFF);
        check_eq("b2b_start2", find_fall(3 + P + CPB * NBITS), 3 + 2 * P);
        check_eq("b2b_d2", decode(3 + 2 * P), 8'h3C);
        check_eq("b2b_sent", bytes_sent, 3);
        check_eq("b2b_rdreq", rd_pulses, 3);
        push(8'h55);
        clear_trace();
        capture(P + 5);
        check_eq("wrap_d", decode(3), 8'h55);
        check_eq("wrap_sent", bytes_sent, 0);

        // tx_en gating
        do_reset();
        push(8'h81); push(8'h11); push(8'h22);
        clear_trace();
        capture(20);
        tx_en = 1'b0;
        capture(P - 15);
        check_eq("gate_d", decode(3), 8'h81);
        check_eq("gate_rdreq", rd_pulses, 1);
        check_eq("gate_nonew", find_fall(CPB * NBITS + 3), -1);
        check_eq("gate_busy", busy, 0);
        check_eq("gate_sent", bytes_sent, 1);
        tx_en = 1'b1;
        clear_trace();
        capture(5);
        tx_en = 1'b0;
        capture(P);
        check_eq("resume_start", find_fall(1), 3);
        check_eq("resume_d", decode(3), 8'h11);
        check_eq("resume_rdreq", rd_pulses, 1);
        check_eq("resume_sent", bytes_sent, 2);

        // FIFO goes empty during REQ
        tx_en = 1'b1;
        clear_trace();
        capture(1);
        force_empty = 1'b1;
        capture(20);
        check_eq("race_rdreq", rd_pulses, 1);
        check_eq("race_busy", busy_tr[2], 0);
        check_eq("race_lows", count_lows(), 0);
        check_eq("race_sent", bytes_sent, 2);
        force_empty = 1'b0;
        clear_trace();
        capture(P + 2);
        check_eq("race_next_d", decode(3), 8'h22);
        check_eq("race_next_sent", bytes_sent, 3);

        // Reset during DATA bit 3 of 0x00
        push(8'h00);
        clear_trace();
        capture(20);
        check_eq("mid_tx_low", tx, 0);
        #1 reset = 1'b1;
        #1;
        check_eq("mid_rst_tx", tx, 1);
        check_eq("mid_rst_busy", busy, 0);
        check_eq("mid_rst_sent", bytes_sent, 0);
        @(negedge clk);
        reset = 1'b0;
        clear_trace();
        capture(10);
        check_eq("post_rst_lows", count_lows(), 0);
        check_eq("post_rst_rdreq", rd_pulses, 0);

`ifdef DRAIN_PARITY_EN
        push(8'h07);
        clear_trace();
        capture(P + 2);
        check_eq("par07_d", decode(3), 8'h07);
        check_eq("par07_bit", trace[3 + CPB * 9 + 1], 1);
        check_eq("par07_len", busy_tr[47], 0);
        check_eq("par07_len_m1", busy_tr[46], 1);
        push(8'h03);
        clear_trace();
        capture(P + 2);
        check_eq("par03_d", decode(3), 8'h03);
        check_eq("par03_bit", trace[3 + CPB * 9 + 1], 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
